// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: forward-select codes,
// scoreboard entry layout and the decoder opcodes that drive id_is_load/id_is_link.
package fwd_hazard_unit_pkg;

    // Scoreboard rd field is sized for the widest supported register address (RA_W <= RA_W_MAX)
    localparam int unsigned RA_W_MAX = 8;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic                v;
        logic [RA_W_MAX-1:0] rd;
        logic                is_load;
        logic                is_link;
    } sb_entry_t;

    // Operand hits an in-flight producer: real read, non-zero register, valid entry, same rd
    function automatic logic sb_hit(input logic use_rs, input logic [RA_W_MAX-1:0] rs,
                                    input logic v, input logic [RA_W_MAX-1:0] rd);
        return use_rs && (rs != '0) && v && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID/EX boundary bundle between the decode stage and the forwarding/hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_wen;
    logic            id_is_load;
    logic            id_is_link;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] ex_alu;
    logic [XLEN-1:0] ex_pc4;
    logic [XLEN-1:0] mem_alu;
    logic [XLEN-1:0] mem_pc4;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] wb_wdata;
    logic            flush;

    logic             stall;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen,
               id_is_load, id_is_link, id_rs1_data, id_rs2_data,
               ex_alu, ex_pc4, mem_alu, mem_pc4, mem_rdata, wb_wdata, flush,
        input  stall, op1, op2, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen,
               id_is_load, id_is_link, id_rs1_data, id_rs2_data,
               ex_alu, ex_pc4, mem_alu, mem_pc4, mem_rdata, wb_wdata, flush,
        output stall, op1, op2, fwd_sel1, fwd_sel2, stall_cnt
    );
endinterface

// File: rtl/fwd_operand_sel.sv
// Per-operand hazard match and youngest-producer forwarding mux (EX > MEM > WB > RF).
module fwd_operand_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic                use_rs,
    input  logic [RA_W-1:0]     rs,
    input  logic [XLEN-1:0]     rf_data,
    input  sb_entry_t           ex_e,
    input  sb_entry_t           mem_e,
    input  logic                wb_v,
    input  logic [RA_W_MAX-1:0] wb_rd,
    input  logic [XLEN-1:0]     ex_alu,
    input  logic [XLEN-1:0]     ex_pc4,
    input  logic [XLEN-1:0]     mem_alu,
    input  logic [XLEN-1:0]     mem_pc4,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic [XLEN-1:0]     wb_wdata,
    output logic [XLEN-1:0]     op_c,
    output fwd_sel_t            sel_c,
    output logic                ex_load_hit_c
);

    logic [RA_W_MAX-1:0] rs_w;
    logic                hit_ex;
    logic                hit_mem;
    logic                hit_wb;

    assign rs_w    = RA_W_MAX'(rs);
    assign hit_ex  = sb_hit(use_rs, rs_w, ex_e.v, ex_e.rd);
    assign hit_mem = sb_hit(use_rs, rs_w, mem_e.v, mem_e.rd);
    assign hit_wb  = sb_hit(use_rs, rs_w, wb_v, wb_rd);

    // A load still in EX has no data yet; the top turns this into a stall
    assign ex_load_hit_c = hit_ex && ex_e.is_load;

    always_comb begin
        op_c  = rf_data;
        sel_c = FWD_RF;
        if (hit_ex) begin
            sel_c = FWD_EX;
            op_c  = ex_e.is_link ? ex_pc4 : ex_alu;
        end else if (hit_mem) begin
            sel_c = FWD_MEM;
            if (mem_e.is_link)
                op_c = mem_pc4;
            else if (mem_e.is_load)
                op_c = mem_rdata;
            else
                op_c = mem_alu;
        end else if (hit_wb) begin
            sel_c = FWD_WB;
            op_c  = wb_wdata;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit at the ID/EX boundary, with its own
// shadow scoreboard of in-flight destinations and a saturating stall counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fwd_hazard_unit_if.slave bus
);

    sb_entry_t           ex_q;
    sb_entry_t           mem_q;
    sb_entry_t           ex_d;
    logic                wb_v_q;
    logic [RA_W_MAX-1:0] wb_rd_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic                ld_hit1_c;
    logic                ld_hit2_c;
    logic                stall_c;
    fwd_sel_t            sel1_c;
    fwd_sel_t            sel2_c;

    assign stall_c = bus.id_valid && !bus.flush && (ld_hit1_c || ld_hit2_c);

    // Next EX entry; stall and flush both inject a bubble
    always_comb begin
        ex_d         = '0;
        ex_d.rd      = RA_W_MAX'(bus.id_rd);
        ex_d.is_load = bus.id_is_load;
        ex_d.is_link = bus.id_is_link;
        ex_d.v       = bus.id_valid && bus.id_wen && (bus.id_rd != '0) && !stall_c && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_v_q  <= 1'b0;
            wb_rd_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_v_q  <= mem_q.v;
            wb_rd_q <= mem_q.rd;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    fwd_operand_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_sel1 (
        .use_rs        (bus.id_use_rs1),
        .rs            (bus.id_rs1),
        .rf_data       (bus.id_rs1_data),
        .ex_e          (ex_q),
        .mem_e         (mem_q),
        .wb_v          (wb_v_q),
        .wb_rd         (wb_rd_q),
        .ex_alu        (bus.ex_alu),
        .ex_pc4        (bus.ex_pc4),
        .mem_alu       (bus.mem_alu),
        .mem_pc4       (bus.mem_pc4),
        .mem_rdata     (bus.mem_rdata),
        .wb_wdata      (bus.wb_wdata),
        .op_c          (bus.op1),
        .sel_c         (sel1_c),
        .ex_load_hit_c (ld_hit1_c)
    );

    fwd_operand_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_sel2 (
        .use_rs        (bus.id_use_rs2),
        .rs            (bus.id_rs2),
        .rf_data       (bus.id_rs2_data),
        .ex_e          (ex_q),
        .mem_e         (mem_q),
        .wb_v          (wb_v_q),
        .wb_rd         (wb_rd_q),
        .ex_alu        (bus.ex_alu),
        .ex_pc4        (bus.ex_pc4),
        .mem_alu       (bus.mem_alu),
        .mem_pc4       (bus.mem_pc4),
        .mem_rdata     (bus.mem_rdata),
        .wb_wdata      (bus.wb_wdata),
        .op_c          (bus.op2),
        .sel_c         (sel2_c),
        .ex_load_hit_c (ld_hit2_c)
    );

    assign bus.stall     = stall_c;
    assign bus.fwd_sel1  = 2'(sel1_c);
    assign bus.fwd_sel2  = 2'(sel2_c);
    assign bus.stall_cnt = stall_cnt_q;

endmodule
